// File: rtl/mux4to1_rr.sv
// Four-channel round-robin collector: merges four valid/ready inputs onto one
// registered output stream, tagging each beat with its source channel.
module mux4to1_rr #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_sel,
    input  logic               out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       out_sel_q, out_sel_d;
    logic [1:0]       last_grant_q, last_grant_d;

    logic [1:0] grant;
    logic [1:0] idx;
    logic       grant_vld;
    logic       load_en;
    logic       xfer;

    // Search starts one past the last winner so every channel gets a turn.
    always_comb begin
        grant     = 2'b00;
        grant_vld = 1'b0;
        idx       = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant_q + 2'(k);
            if (!grant_vld && in_valid[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        load_en  = !out_valid_q || out_ready;
        in_ready = 4'b0000;
        if (!rst && load_en && grant_vld) begin
            in_ready = 4'b0001 << grant;
        end
        xfer = |in_ready;
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            out_valid_d  = 1'b1;
            out_data_d   = in_data[int'(grant)*WIDTH +: WIDTH];
            out_sel_d    = grant;
            last_grant_d = grant;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Pointer resets to 3 so channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sel_q    <= 2'b00;
            last_grant_q <= 2'b11;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux4to1_rr.sv
// Bench for mux4to1_rr: directed scenarios plus a randomized run, all checked
// against a transaction-level model of the collector.
module tb_mux4to1_rr;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [4*W-1:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;
    logic         out_ready;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state
    bit       m_valid;
    int       m_data;
    int       m_sel;
    int       m_lg;

    mux4to1_rr #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic int model_grant();
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_lg + k) % 4;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        int g;
        g = model_grant();
        if (rst || g < 0 || (m_valid && !out_ready)) return 4'b0000;
        return 4'(1 << g);
    endfunction

    // One clock: advance the model with the inputs seen at the edge.
    task automatic advance();
        logic [3:0] r;
        int g;
        r = model_ready();
        g = model_grant();
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = 0; m_sel = 0; m_lg = 3;
        end else if (r != 4'b0000) begin
            m_valid = 1; m_data = int'(in_data[g*W +: W]); m_sel = g; m_lg = g;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 4'b1111; out_ready = 1;
        for (int i = 0; i < 4; i++) in_data[i*W +: W] = 8'hA0 + 8'(i);
        #1;
        advance();
        advance();
        n_cmp++;
        if (in_ready !== 4'b0000 || out_valid !== 1'b0 || out_sel !== 2'b00 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_sel=%b out_data=%h, want 0000 0 00 00",
                     in_ready, out_valid, out_sel, out_data);
        end
        rst = 0; #1;
        n_cmp++;
        if (in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: in_ready=%b want 0001", in_ready);
        end
        advance();
        n_cmp++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'hA0) begin
            n_fail++;
            $display("FAIL reset_first_beat: valid=%b sel=%0d data=%h want 1 0 a0", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_round_robin();
        int exp_sel;
        exp_sel = 0;
        for (int c = 0; c < 12; c++) begin
            exp_sel = (exp_sel + 1) % 4;
            n_cmp++;
            if (in_ready !== model_ready() || in_ready !== 4'(1 << exp_sel)) begin
                n_fail++;
                $display("FAIL rr_ready c%0d: in_ready=%b want %b", c, in_ready, 4'(1 << exp_sel));
            end
            advance();
            n_cmp++;
            if (out_valid !== 1'b1 || int'(out_sel) != exp_sel || out_data !== 8'hA0 + 8'(exp_sel)) begin
                n_fail++;
                $display("FAIL rr_beat c%0d: valid=%b sel=%0d data=%h want 1 %0d %h",
                         c, out_valid, out_sel, out_data, exp_sel, 8'hA0 + 8'(exp_sel));
            end
        end
    endtask

    task automatic test_sparse_wrap();
        int exp_seq [3] = '{2, 0, 1};
        in_valid = 4'b0100; #1;
        for (int s = 0; s < 3; s++) begin
            advance();
            if (s == 0) begin in_valid = 4'b0011; #1; end
            n_cmp++;
            if (out_valid !== 1'b1 || int'(out_sel) != exp_seq[s] || int'(out_data) != m_data) begin
                n_fail++;
                $display("FAIL sparse step%0d: valid=%b sel=%0d data=%h want 1 %0d %h",
                         s, out_valid, out_sel, out_data, exp_seq[s], m_data[7:0]);
            end
        end
        in_valid = 4'b0000; #1;
        advance();
    endtask

    task automatic test_backpressure();
        in_valid = 4'b0010; in_data[1*W +: W] = 8'h5A; #1;
        advance();
        out_ready = 0; in_valid = 4'b1010; in_data[3*W +: W] = 8'hC3; #1;
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'h5A) begin
                n_fail++;
                $display("FAIL stall c%0d: in_ready=%b valid=%b sel=%0d data=%h want 0000 1 1 5a",
                         c, in_ready, out_valid, out_sel, out_data);
            end
            advance();
        end
        out_ready = 1; #1;
        n_cmp++;
        if (in_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL stall_release_ready: in_ready=%b want 1000", in_ready);
        end
        advance();
        in_valid = 4'b0000; #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL stall_release_beat: valid=%b sel=%0d data=%h want 1 3 c3", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_single_stream();
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        in_valid = 4'b0100;
        for (int b = 0; b < 3; b++) begin
            in_data[2*W +: W] = vals[b]; #1;
            advance();
            n_cmp++;
            if (out_valid !== 1'b1 || out_sel !== 2'b10 || out_data !== vals[b]) begin
                n_fail++;
                $display("FAIL stream beat%0d: valid=%b sel=%b data=%h want 1 10 %h",
                         b, out_valid, out_sel, out_data, vals[b]);
            end
        end
        in_valid = 4'b0000; #1;
        advance();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 8'h33 || out_sel !== 2'b10) begin
            n_fail++;
            $display("FAIL stream_idle: valid=%b sel=%b data=%h want 0 10 33", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_reset_stall();
        in_valid = 4'b0001; in_data[0] = 1'b1; #1;
        advance();
        out_ready = 0; in_valid = 4'b1100; #1;
        advance();
        advance();
        rst = 1; #1;
        advance();
        rst = 0; #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_stall: valid=%b in_ready=%b want 0 0100", out_valid, in_ready);
        end
        advance();
        n_cmp++;
        if (out_valid !== 1'b1 || out_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL reset_stall_grant: valid=%b sel=%0d want 1 2", out_valid, out_sel);
        end
        out_ready = 1; in_valid = 4'b0000; #1;
        advance();
    endtask

    task automatic test_random();
        int bad;
        int since [4];
        bad = 0;
        for (int i = 0; i < 4; i++) since[i] = 0;
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            #1;
            n_cmp++;
            if (in_ready !== model_ready() || out_valid !== m_valid ||
                (m_valid && (int'(out_sel) != m_sel || int'(out_data) != m_data))) begin
                n_fail++;
                if (bad < 5)
                    $display("FAIL random c%0d: in_ready=%b valid=%b sel=%0d data=%h want %b %b %0d %h",
                             c, in_ready, out_valid, out_sel, out_data, model_ready(), m_valid, m_sel, m_data[7:0]);
                bad++;
            end
            advance();
        end
        rst = 0; out_ready = 1;
        // fairness: four channels held valid, each granted within four transfers
        in_valid = 4'b1111; #1;
        for (int c = 0; c < 8; c++) begin
            advance();
            for (int i = 0; i < 4; i++) since[i] = (int'(out_sel) == i) ? 0 : since[i] + 1;
        end
        n_cmp++;
        if (since[0] > 3 || since[1] > 3 || since[2] > 3 || since[3] > 3) begin
            n_fail++;
            $display("FAIL fairness: gaps %0d %0d %0d %0d want all <=3", since[0], since[1], since[2], since[3]);
        end
    endtask

    initial begin
        m_valid = 0; m_data = 0; m_sel = 0; m_lg = 3;
        in_data = '0;
        @(posedge clk); #1;
        test_reset();
        test_round_robin();
        test_sparse_wrap();
        test_backpressure();
        test_single_stream();
        test_reset_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4to1_rr.md
# mux4to1_rr

Four-channel round-robin collector: the gathering counterpart of the 1-to-4 demultiplexer. It accepts beats from four valid/ready input channels and merges them onto one registered output stream. Each output beat is tagged with its source channel, using the same 2-bit select encoding that the demultiplexer uses on {s1, s0}. The block sits upstream of any single-stream consumer. A demux1to4 driven by out_sel can fan the stream back out.

## Interface
- WIDTH, default 8: data width per channel.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  input  4  bit i set means channel i presents a beat.
- in_data  input  4*WIDTH  channel i data is in_data[i*WIDTH +: WIDTH].
- in_ready  output  4  bit i set means channel i beat is accepted this cycle. Combinational.
- out_valid  output  1  the output register holds a beat.
- out_data  output  WIDTH  data of the held beat.
- out_sel  output  2  source channel of the held beat. 2'b00 is channel 0, 2'b11 is channel 3.
- out_ready  input  1  the consumer accepts the held beat this cycle.

## Operation
- Storage is one output register (out_valid, out_data, out_sel) plus a 2-bit pointer last_grant.
- The output register has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load_en = !out_valid || out_ready. The register can take a new beat when it is empty, or when it is full and draining this cycle.
- Arbitration is combinational:
  - Search channels in the order last_grant+1, last_grant+2, last_grant+3, last_grant, modulo 4.
  - grant is the first channel in that order with in_valid set.
  - If no channel is valid, there is no grant.
- in_ready[i] = load_en && any in_valid && (grant == i). At most one in_ready bit is set per cycle.
- Transfer on channel i: in_valid[i] && in_ready[i]. On the next edge:
  - out_data <= that channel's data.
  - out_sel <= i.
  - out_valid <= 1.
  - last_grant <= i.
- Drain with no transfer (out_valid && out_ready, no transfer this cycle): out_valid <= 0 on the next edge. out_data and out_sel keep their values.
- Simultaneous drain and transfer: the register reloads with the new beat and out_valid stays 1. The output sustains one beat per cycle.
- Stall (out_valid && !out_ready):
  - in_ready is all zero.
  - out_valid, out_data and out_sel are held stable.
  - last_grant does not change.
- last_grant changes only on a transfer.
- Channels that are not granted are not dropped. Their beats wait until they are granted.
- Fairness: a continuously valid channel is granted within 4 transfers.
- Input contract: once a source raises in_valid, it holds in_valid and in_data until the beat is accepted. The block does not check this.

## Timing
- Reset values, taking effect on the edge where rst=1:
  - out_valid=0, out_data=0, out_sel=2'b00.
  - last_grant=2'b11, so channel 0 has highest priority first.
- While rst=1, in_ready is forced to 4'b0000.
- Reset during operation: any held beat is discarded and the priority pointer returns to last_grant=2'b11.
- Latency: a beat accepted at edge N appears on the outputs with out_valid=1 after edge N, i.e. one cycle.
- Throughput: one beat per clock when out_ready is held at 1 and at least one channel is valid.
- Combinational paths:
  - in_ready depends on in_valid, out_valid and out_ready.
  - There is no combinational path from in_data to any output.
- Wrap-around: the search order after last_grant=3 is 0, 1, 2, 3.
- Only one channel valid: that channel is granted every cycle, regardless of last_grant.

## Test plan
- Reset check:
  - Stimulus: in_valid=4'b1111, rst=1 for 2 cycles.
  - Required: in_ready=0000, out_valid=0, out_sel=00, out_data=0.
  - After release, the first transfer is from channel 0.
- Round-robin at full rate:
  - Stimulus: WIDTH=8; channel i holds data 8'hA0+i with valid set constantly; out_ready=1.
  - Required: out_sel sequence 0,1,2,3,0,1,… with out_data A0,A1,A2,A3,A0,… and one beat per cycle.
- Sparse requests with wrap:
  - Stimulus: after a channel-2 transfer, only channels 0 and 1 are valid.
  - Required: channel 0 is granted next, then channel 1. Channel 3 is skipped with no idle cycle.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while channels 1 and 3 are valid.
  - Required: out_valid=1, out_data and out_sel held, in_ready=0000 throughout.
  - On release: the held beat drains and channel 3 is loaded in the same cycle, since last_grant was 1.
- Single-channel streaming and idle:
  - Stimulus: channel 2 sends 8'h11, 8'h22, 8'h33 back-to-back, then in_valid goes to 0.
  - Required: out_sel=10 for three consecutive cycles with those data values, then out_valid=0 on the following cycle.
- Reset during a stall:
  - Stimulus: a beat is held with out_ready=0, then rst=1 for 1 cycle.
  - Required: out_valid=0 on the next cycle; the next grant goes to the lowest-numbered valid channel.
